// File: rtl/gripper_cmd_pkg.sv
// Shared definitions for the gripper UART command path: ASCII byte codes,
// parser state encoding and a small character-class helper.
package gripper_cmd_pkg;

    localparam logic [7:0] CHAR_G   = 8'h47;
    localparam logic [7:0] CHAR_R   = 8'h52;
    localparam logic [7:0] CHAR_P   = 8'h50;
    localparam logic [7:0] CHAR_DOT = 8'h2E;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_0   = 8'h30;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_CR_G = 4'd1;
    localparam logic [3:0] ST_WAIT_CR_R = 4'd2;
    localparam logic [3:0] ST_P_D3      = 4'd3;
    localparam logic [3:0] ST_P_D2      = 4'd4;
    localparam logic [3:0] ST_P_DOT     = 4'd5;
    localparam logic [3:0] ST_P_D1      = 4'd6;
    localparam logic [3:0] ST_P_D0      = 4'd7;
    localparam logic [3:0] ST_WAIT_CR_P = 4'd8;
    localparam logic [3:0] ST_FLUSH     = 4'd9;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        WAIT_CR_G = ST_WAIT_CR_G,
        WAIT_CR_R = ST_WAIT_CR_R,
        P_D3      = ST_P_D3,
        P_D2      = ST_P_D2,
        P_DOT     = ST_P_DOT,
        P_D1      = ST_P_D1,
        P_D0      = ST_P_D0,
        WAIT_CR_P = ST_WAIT_CR_P,
        FLUSH     = ST_FLUSH
    } state_t;

    // True for ASCII '0'..'9'; the low nibble is then the BCD digit.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CHAR_0) && (c <= (CHAR_0 + 8'd9));
    endfunction

endpackage

// File: rtl/Generic_counter.sv
// Free-running up counter that wraps to zero after COUNTER_MAX and flags
// the terminal count. RESET is asynchronous and active-high.
module Generic_counter #(
    parameter int COUNTER_MAX = 9,
    parameter int WIDTH       = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    output logic DONE
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(COUNTER_MAX);

    logic [WIDTH-1:0] count_r;

    // Count while enabled, wrapping after the terminal value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_r <= '0;
        end else if (ENABLE) begin
            if (count_r == MAX_VAL) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign DONE = (count_r == MAX_VAL);

endmodule

// File: rtl/command_parser.sv
// Receive-side ASCII command decoder for the gripper UART link.
// Parses G<CR>, R<CR> and Pdd.dd<CR> frames into one-cycle pulses and a
// committed BCD setpoint. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module command_parser
    import gripper_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int TIMEOUT_WIDTH  = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [3:0] SP_DEC3,
    output logic [3:0] SP_DEC2,
    output logic [3:0] SP_DEC1,
    output logic [3:0] SP_DEC0,
    output logic       setpoint_valid,
    output logic       grip_cmd,
    output logic       release_cmd,
    output logic       cmd_error,
    output logic       busy
);

    state_t     state_r, state_s;
    logic [3:0] sh3_r, sh2_r, sh1_r, sh0_r;
    logic [3:0] sh3_s, sh2_s, sh1_s, sh0_s;
    logic [3:0] sp3_r, sp2_r, sp1_r, sp0_r;
    logic       grip_r, rel_r, spv_r, err_r, busy_r;
    logic       grip_s, rel_s, spv_s, err_s;
    logic       timeout_s;
    logic [3:0] digit_s;

    // Digit value is only used after the range check, so the nibble subtract is exact.
    assign digit_s = rx_data[3:0] - CHAR_0[3:0];

`ifdef CMD_TIMEOUT_EN
    logic cnt_done_s;
    logic cnt_reset_s;

    // A received byte restarts the inter-byte interval.
    assign cnt_reset_s = RESET | rx_valid;

    Generic_counter #(
        .COUNTER_MAX (TIMEOUT_CYCLES - 1),
        .WIDTH       (TIMEOUT_WIDTH)
    ) u_timeout (
        .CLK    (CLK),
        .RESET  (cnt_reset_s),
        .ENABLE (busy_r),
        .DONE   (cnt_done_s)
    );

    assign timeout_s = cnt_done_s & (state_r != IDLE);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, shadow digit capture and pulse decode.
    always_comb begin
        state_s = state_r;
        sh3_s   = sh3_r;
        sh2_s   = sh2_r;
        sh1_s   = sh1_r;
        sh0_s   = sh0_r;
        grip_s  = 1'b0;
        rel_s   = 1'b0;
        spv_s   = 1'b0;
        err_s   = 1'b0;
        if (rx_valid) begin
            // A byte always takes priority over a coincident timeout.
            case (state_r)
                IDLE: begin
                    if (rx_data == CHAR_G) begin
                        state_s = WAIT_CR_G;
                    end else if (rx_data == CHAR_R) begin
                        state_s = WAIT_CR_R;
                    end else if (rx_data == CHAR_P) begin
                        state_s = P_D3;
                    end else if (rx_data == CHAR_LF) begin
                        state_s = IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = FLUSH;
                    end
                end
                P_D3, P_D2, P_D1, P_D0: begin
                    if (is_digit(rx_data)) begin
                        case (state_r)
                            P_D3:    begin sh3_s = digit_s; state_s = P_D2;      end
                            P_D2:    begin sh2_s = digit_s; state_s = P_DOT;     end
                            P_D1:    begin sh1_s = digit_s; state_s = P_D0;      end
                            default: begin sh0_s = digit_s; state_s = WAIT_CR_P; end
                        endcase
                    end else begin
                        err_s   = 1'b1;
                        state_s = FLUSH;
                    end
                end
                P_DOT: begin
                    if (rx_data == CHAR_DOT) begin
                        state_s = P_D1;
                    end else begin
                        err_s   = 1'b1;
                        state_s = FLUSH;
                    end
                end
                WAIT_CR_G, WAIT_CR_R, WAIT_CR_P: begin
                    if (rx_data == CHAR_CR) begin
                        grip_s  = (state_r == WAIT_CR_G);
                        rel_s   = (state_r == WAIT_CR_R);
                        spv_s   = (state_r == WAIT_CR_P);
                        state_s = IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = FLUSH;
                    end
                end
                FLUSH: begin
                    if ((rx_data == CHAR_CR) || (rx_data == CHAR_LF)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FLUSH;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if (timeout_s) begin
            // Abandoned frame: report once, but a flush is already reported.
            err_s   = (state_r != FLUSH);
            state_s = IDLE;
        end else begin
            state_s = state_r;
        end
    end

    // State, shadow digits, committed setpoint and registered pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            sh3_r   <= 4'd0;
            sh2_r   <= 4'd0;
            sh1_r   <= 4'd0;
            sh0_r   <= 4'd0;
            sp3_r   <= 4'd0;
            sp2_r   <= 4'd0;
            sp1_r   <= 4'd0;
            sp0_r   <= 4'd0;
            grip_r  <= 1'b0;
            rel_r   <= 1'b0;
            spv_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sh3_r   <= sh3_s;
            sh2_r   <= sh2_s;
            sh1_r   <= sh1_s;
            sh0_r   <= sh0_s;
            if (spv_s) begin
                sp3_r <= sh3_r;
                sp2_r <= sh2_r;
                sp1_r <= sh1_r;
                sp0_r <= sh0_r;
            end else begin
                sp3_r <= sp3_r;
                sp2_r <= sp2_r;
                sp1_r <= sp1_r;
                sp0_r <= sp0_r;
            end
            grip_r  <= grip_s;
            rel_r   <= rel_s;
            spv_r   <= spv_s;
            err_r   <= err_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign SP_DEC3        = sp3_r;
    assign SP_DEC2        = sp2_r;
    assign SP_DEC1        = sp1_r;
    assign SP_DEC0        = sp0_r;
    assign setpoint_valid = spv_r;
    assign grip_cmd       = grip_r;
    assign release_cmd    = rel_r;
    assign cmd_error      = err_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_command_parser.sv
// Self-checking bench for command_parser: directed frames from the test plan
// plus random byte streams, checked every cycle against a frame-grammar model.
// Build with CMD_TIMEOUT_EN defined to exercise the timeout (TIMEOUT_CYCLES=100).
module tb_command_parser;

`ifdef CMD_TIMEOUT_EN
    localparam int TCYC  = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TCYC  = 10000000;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] sp3, sp2, sp1, sp0;
    logic       spv, grip, rel, err, bsy;

    command_parser #(
        .TIMEOUT_CYCLES (TCYC),
        .TIMEOUT_WIDTH  (24)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .SP_DEC3        (sp3),
        .SP_DEC2        (sp2),
        .SP_DEC1        (sp1),
        .SP_DEC0        (sp0),
        .setpoint_valid (spv),
        .grip_cmd       (grip),
        .release_cmd    (rel),
        .cmd_error      (err),
        .busy           (bsy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame grammar level) ----------------
    byte        fbuf[$];
    bit         flushing;
    int         idle_cnt;
    bit         e_grip, e_rel, e_spv, e_err;
    logic [15:0] e_sp;
    int         checks   = 0;
    int         failures = 0;

    // 0: not a prefix of any legal frame, 1: legal prefix, 2: complete frame
    function automatic int classify(input byte f[$]);
        int n = f.size();
        if (n == 0) return 1;
        if (f[0] == 8'h47 || f[0] == 8'h52) begin
            if (n == 1) return 1;
            if (n == 2 && f[1] == 8'h0D) return 2;
            return 0;
        end
        if (f[0] != 8'h50 || n > 7) return 0;
        for (int i = 1; i < n; i++) begin
            if (i == 3) begin
                if (f[i] != 8'h2E) return 0;
            end else if (i == 6) begin
                if (f[i] != 8'h0D) return 0;
            end else begin
                if (f[i] < 8'h30 || f[i] > 8'h39) return 0;
            end
        end
        return (n == 7) ? 2 : 1;
    endfunction

    task automatic model_reset();
        fbuf.delete();
        flushing = 1'b0;
        idle_cnt = 0;
        e_sp     = 16'h0000;
    endtask

    task automatic model_byte(input byte b);
        int r;
        idle_cnt = 0;
        if (flushing) begin
            if (b == 8'h0D || b == 8'h0A) flushing = 1'b0;
        end else if (fbuf.size() == 0 && b == 8'h0A) begin
            // stray LF between frames is ignored
        end else begin
            fbuf.push_back(b);
            r = classify(fbuf);
            if (r == 0) begin
                e_err    = 1'b1;
                flushing = 1'b1;
                fbuf.delete();
            end else if (r == 2) begin
                if (fbuf[0] == 8'h47) e_grip = 1'b1;
                else if (fbuf[0] == 8'h52) e_rel = 1'b1;
                else begin
                    e_spv = 1'b1;
                    e_sp  = {fbuf[1][3:0], fbuf[2][3:0], fbuf[4][3:0], fbuf[5][3:0]};
                end
                fbuf.delete();
            end
        end
    endtask

    task automatic model_idle();
        if (flushing || fbuf.size() > 0) begin
            idle_cnt++;
            if (TO_EN && idle_cnt == TCYC) begin
                if (!flushing) e_err = 1'b1;
                flushing = 1'b0;
                fbuf.delete();
                idle_cnt = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("grip_cmd",       {15'd0, grip}, {15'd0, e_grip});
        chk("release_cmd",    {15'd0, rel},  {15'd0, e_rel});
        chk("setpoint_valid", {15'd0, spv},  {15'd0, e_spv});
        chk("cmd_error",      {15'd0, err},  {15'd0, e_err});
        chk("busy",           {15'd0, bsy},  {15'd0, (flushing || fbuf.size() > 0)});
        chk("sp_dec",         {sp3, sp2, sp1, sp0}, e_sp);
        chk("pulse_onehot",   {15'd0, ($countones({grip, rel, spv, err}) <= 1)}, 16'd1);
    endtask

    // One clock: drive at a falling edge, sample at the next falling edge.
    task automatic step(input bit v, input byte b);
        rx_valid = v;
        rx_data  = v ? b : 8'h00;
        @(negedge clk);
        e_grip = 1'b0; e_rel = 1'b0; e_spv = 1'b0; e_err = 1'b0;
        if (v) model_byte(b);
        else   model_idle();
        check_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        #2;
        model_reset();
        e_grip = 1'b0; e_rel = 1'b0; e_spv = 1'b0; e_err = 1'b0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        byte alpha[12];
        alpha = '{8'h47, 8'h52, 8'h50, 8'h30, 8'h35, 8'h39, 8'h2E,
                  8'h0D, 8'h0A, 8'h41, 8'h70, 8'h3A};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        e_grip = 1'b0; e_rel = 1'b0; e_spv = 1'b0; e_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);

        // G and R frames with gaps; setpoint untouched
        send_str("G\r");
        chk("grip_after_cr", {15'd0, grip}, 16'd1);
        gap(5);
        send_str("R\r");
        chk("release_after_cr", {15'd0, rel}, 16'd1);
        chk("sp_still_zero", {sp3, sp2, sp1, sp0}, 16'h0000);
        gap(5);

        // back-to-back setpoint with CR LF ending
        send_str("P12.34\r");
        chk("spv_after_cr", {15'd0, spv}, 16'd1);
        chk("sp_1234", {sp3, sp2, sp1, sp0}, 16'h1234);
        send_str("\n");
        gap(3);

        // malformed digit: error on 'A', busy until CR, setpoint kept
        send_str("P1A");
        chk("err_on_A", {15'd0, err}, 16'd1);
        send_str(".00");
        chk("busy_in_flush", {15'd0, bsy}, 16'd1);
        send_str("\r");
        chk("busy_after_flush", {15'd0, bsy}, 16'd0);
        chk("sp_kept_1234", {sp3, sp2, sp1, sp0}, 16'h1234);
        send_str("G\r");
        gap(2);

        // lowercase frame: single error only
        send_str("p05.00\r");
        gap(2);

        // reset mid-frame, then a fresh setpoint
        send_str("P99.");
        pulse_reset();
        send_str("P00.50\r");
        chk("sp_0050", {sp3, sp2, sp1, sp0}, 16'h0050);
        gap(2);

        // inter-byte timeout behaviour
        send_str("P1");
        if (TO_EN) begin
            gap(TCYC - 1);
            chk("no_err_before_timeout", {15'd0, err}, 16'd0);
            gap(1);
            chk("err_at_timeout", {15'd0, err}, 16'd1);
            chk("idle_after_timeout", {15'd0, bsy}, 16'd0);
            gap(3);
            // byte arriving on the expiry cycle wins
            send_str("P1");
            gap(TCYC - 1);
            send_str("2.34\r");
            chk("byte_wins_sp", {sp3, sp2, sp1, sp0}, 16'h1234);
            send_str("P1");
            send_str("x");
            gap(TCYC + 3);
        end else begin
            gap(1000);
            chk("still_waiting", {15'd0, bsy}, 16'd1);
            send_str("\r\n");
        end
        gap(2);

        // random mix of legal frames and junk bytes
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 2))
                    0: send_str("G\r");
                    1: send_str("R\r");
                    default: begin
                        step(1'b1, 8'h50);
                        step(1'b1, byte'(8'h30 + $urandom_range(0, 9)));
                        step(1'b1, byte'(8'h30 + $urandom_range(0, 9)));
                        step(1'b1, 8'h2E);
                        step(1'b1, byte'(8'h30 + $urandom_range(0, 9)));
                        step(1'b1, byte'(8'h30 + $urandom_range(0, 9)));
                        step(1'b1, 8'h0D);
                    end
                endcase
                if ($urandom_range(0, 1) == 1) step(1'b1, 8'h0A);
            end else begin
                for (int k = 0; k < $urandom_range(1, 4); k++)
                    step(1'b1, alpha[$urandom_range(0, 11)]);
            end
            gap($urandom_range(0, 3));
        end
        send_str("\r\n");
        gap(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
